// File: rtl/uart_tx_arbiter_pkg.sv
// Shared state type and sizing helpers for the UART transmit arbiter.
package uart_tx_arbiter_pkg;

  localparam int DATA_W = 8;

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} arb_state_t;

  function automatic int req_idx_w(input int nreq);
    return (nreq > 2) ? $clog2(nreq) : 1;
  endfunction

  function automatic int timeout_w(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester streams in, single UART stream out; master is the arbiter side, slave the surroundings.
interface uart_tx_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int DATA_W = uart_tx_arbiter_pkg::DATA_W
);
  import uart_tx_arbiter_pkg::*;
  localparam int IDX_W = req_idx_w(NREQ);

  logic [NREQ*DATA_W-1:0] req_tdata;
  logic [NREQ-1:0]        req_tvalid;
  logic [NREQ-1:0]        req_tlast;
  logic [NREQ-1:0]        req_tready;
  logic [DATA_W-1:0]      m_tdata;
  logic                   m_tvalid;
  logic                   m_tready;
  logic [IDX_W-1:0]       grant_id;
  logic                   busy;

  modport master (
    input  req_tdata, req_tvalid, req_tlast, m_tready,
    output req_tready, m_tdata, m_tvalid, grant_id, busy
  );

  modport slave (
    output req_tdata, req_tvalid, req_tlast, m_tready,
    input  req_tready, m_tdata, m_tvalid, grant_id, busy
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin pick: first set request at or after last+1 (mod NREQ).
module uart_tx_arbiter_rr_picker #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] pick,
  output logic             any_req
);

  int best_d;
  int d;

  // Rotation distance from last+1 plays the role of the priority encoder input.
  always_comb begin
    pick   = '0;
    best_d = NREQ;
    d      = 0;
    for (int j = 0; j < NREQ; j++) begin
      d = j - int'(last) - 1;
      if (d < 0) d = d + NREQ;
      if (req[j] && (d < best_d)) begin
        best_d = d;
        pick   = IDX_W'(j);
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART byte stream among NREQ requesters, grant held per packet.
// First byte on m_tvalid two cycles after request; then one beat per cycle, stalled by m_tready.
module uart_tx_arbiter #(
  parameter int NREQ         = 4,
  parameter int DATA_W       = uart_tx_arbiter_pkg::DATA_W,
  parameter int LOCK_ON_LAST = 1,
  parameter int TIMEOUT      = 255
) (
  input logic               clk,
  input logic               n_rst,
  uart_tx_arbiter_if.master bus
);
  import uart_tx_arbiter_pkg::*;

  localparam int IDX_W = req_idx_w(NREQ);
  localparam int TO_W  = timeout_w(TIMEOUT);

  arb_state_t        state, state_nxt;
  logic [IDX_W-1:0]  grant, last, pick;
  logic [TO_W-1:0]   to_cnt;
  logic [NREQ-1:0]   tready;
  logic [DATA_W-1:0] grant_dat;
  logic              any_req, grant_vld, grant_last, rdy, accept, to_hit, rel;

  uart_tx_arbiter_rr_picker #(.NREQ(NREQ), .IDX_W(IDX_W)) u_picker (
    .req     (bus.req_tvalid),
    .last    (last),
    .pick    (pick),
    .any_req (any_req)
  );

  assign grant_vld  = bus.req_tvalid[grant];
  assign grant_last = bus.req_tlast[grant];
  assign grant_dat  = bus.req_tdata[grant*DATA_W +: DATA_W];
  assign rdy        = !bus.m_tvalid || bus.m_tready;
  assign accept     = (state == LOCKED) && grant_vld && rdy;
  // Release lands on the same edge at which the idle count would reach TIMEOUT.
  assign to_hit     = (TIMEOUT != 0) && (state == LOCKED) && !grant_vld &&
                      (to_cnt == TO_W'(TIMEOUT - 1));
  assign rel        = (accept && ((LOCK_ON_LAST == 0) || grant_last)) || to_hit;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = LOCKED;
      LOCKED:  if (rel)     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tready = '0;
    for (int j = 0; j < NREQ; j++)
      tready[j] = (state == LOCKED) && (grant == IDX_W'(j)) && rdy;
  end

  assign bus.req_tready = tready;
  assign bus.grant_id   = grant;
  assign bus.busy       = (state == LOCKED) || bus.m_tvalid;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      grant <= '0;
      last  <= IDX_W'(NREQ - 1);
    end else begin
      if ((state == IDLE) && any_req) grant <= pick;
      if (rel)                        last  <= grant;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      to_cnt <= '0;
    else if ((state != state_nxt) || accept || (state == IDLE))
      to_cnt <= '0;
    else if (!grant_vld && (to_cnt != '1))
      to_cnt <= to_cnt + 1'b1;
  end

  // Accept and drain in the same cycle keeps m_tvalid high with the new byte.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bus.m_tvalid <= 1'b0;
      bus.m_tdata  <= '0;
    end else if (accept) begin
      bus.m_tvalid <= 1'b1;
      bus.m_tdata  <= grant_dat;
    end else if (bus.m_tready) begin
      bus.m_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: packet arbiter (TIMEOUT=8) plus a per-beat re-arbitration instance.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic n_rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  uart_tx_arbiter_if #(.NREQ(NREQ), .DATA_W(8)) b0 ();
  uart_tx_arbiter_if #(.NREQ(NREQ), .DATA_W(8)) b1 ();

  uart_tx_arbiter #(.NREQ(NREQ), .DATA_W(8), .LOCK_ON_LAST(1), .TIMEOUT(8)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (b0)
  );

  uart_tx_arbiter #(.NREQ(NREQ), .DATA_W(8), .LOCK_ON_LAST(0), .TIMEOUT(8)) dut_nl (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (b1)
  );

  // Source queues per requester: bit 8 = tlast, bits 7:0 = byte.
  logic [8:0] q0 [NREQ][$];
  logic [8:0] q1 [NREQ][$];
  logic [7:0] out0 [$];
  logic [7:0] out1 [$];
  int         outc0 [$];

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (b0.m_tvalid && b0.m_tready) begin
      out0.push_back(b0.m_tdata);
      outc0.push_back(cyc);
    end
    if (b1.m_tvalid && b1.m_tready) out1.push_back(b1.m_tdata);
  end

  // Requester model: hold the head beat until a handshake is seen at a clock edge.
  initial begin
    logic [NREQ-1:0] fire0, fire1;
    logic [8:0]      h0, h1;
    fire0 = '0;
    fire1 = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (fire0[i] && (q0[i].size() > 0)) void'(q0[i].pop_front());
        if (fire1[i] && (q1[i].size() > 0)) void'(q1[i].pop_front());
        h0 = (q0[i].size() > 0) ? q0[i][0] : 9'h000;
        h1 = (q1[i].size() > 0) ? q1[i][0] : 9'h000;
        b0.req_tvalid[i]       = (q0[i].size() > 0);
        b0.req_tlast[i]        = h0[8];
        b0.req_tdata[i*8 +: 8] = h0[7:0];
        b1.req_tvalid[i]       = (q1[i].size() > 0);
        b1.req_tlast[i]        = h1[8];
        b1.req_tdata[i*8 +: 8] = h1[7:0];
      end
      #1;
      fire0 = b0.req_tvalid & b0.req_tready;
      fire1 = b1.req_tvalid & b1.req_tready;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Compare the captured UART byte order with exp (first byte in the most significant position).
  task automatic check_stream(input string tag, input int sel, input int n, input logic [63:0] exp);
    logic [7:0] got [$];
    if (sel == 0) got = out0;
    else          got = out1;
    check($sformatf("%s_len", tag), got.size(), n);
    for (int k = 0; k < n; k++)
      check($sformatf("%s_b%0d", tag, k), (k < got.size()) ? got[k] : 8'hxx,
            exp[(n-1-k)*8 +: 8]);
    if (sel == 0) begin
      out0.delete();
      outc0.delete();
    end else begin
      out1.delete();
    end
  endtask

  initial begin
    n_rst = 1'b1;
    b0.m_tready = 1'b1;
    b1.m_tready = 1'b1;
    #1 n_rst = 1'b0;
    #1;
    check("rst_m_tvalid", b0.m_tvalid, 0);
    check("rst_m_tdata", b0.m_tdata, 0);
    check("rst_req_tready", b0.req_tready, 0);
    check("rst_grant_id", b0.grant_id, 0);
    check("rst_busy", b0.busy, 0);
    step(2);
    n_rst = 1'b1;
    step(2);

    // Single requester: grant at +1, first byte on the output at +2.
    q0[1].push_back(9'h048);
    q0[1].push_back(9'h149);
    step(1);
    check("t2_grant", b0.grant_id, 1);
    check("t2_busy", b0.busy, 1);
    check("t2_vld_early", b0.m_tvalid, 0);
    step(1);
    check("t2_vld_first", b0.m_tvalid, 1);
    check("t2_dat0", b0.m_tdata, 8'h48);
    step(1);
    check("t2_vld_second", b0.m_tvalid, 1);
    check("t2_dat1", b0.m_tdata, 8'h49);
    step(1);
    check("t2_vld_done", b0.m_tvalid, 0);
    check("t2_idle", b0.busy, 0);
    check_stream("t2", 0, 2, 64'h4849);

    // last is now 1, so req2 outranks req0.
    q0[0].push_back(9'h160);
    q0[2].push_back(9'h170);
    step(8);
    check_stream("t2_rot", 0, 2, 64'h7060);

    // Reset while a byte sits stalled in the output register.
    b0.m_tready = 1'b0;
    q0[3].push_back(9'h0A1);
    q0[3].push_back(9'h0A2);
    q0[3].push_back(9'h1A3);
    step(4);
    check("t1_pre_vld", b0.m_tvalid, 1);
    check("t1_pre_dat", b0.m_tdata, 8'hA1);
    #1 n_rst = 1'b0;
    #1;
    check("t1_async_vld", b0.m_tvalid, 0);
    check("t1_async_dat", b0.m_tdata, 0);
    check("t1_async_rdy", b0.req_tready, 0);
    check("t1_async_busy", b0.busy, 0);
    for (int i = 0; i < NREQ; i++) q0[i].delete();
    b0.m_tready = 1'b1;
    step(2);
    n_rst = 1'b1;
    step(2);
    check("t1_no_output", out0.size(), 0);

    // Contention from reset: requester 0 first, then strict rotation.
    q0[0].push_back(9'h010); q0[0].push_back(9'h111);
    q0[2].push_back(9'h020); q0[2].push_back(9'h121);
    q0[3].push_back(9'h030); q0[3].push_back(9'h131);
    step(16);
    check_stream("t3", 0, 6, 64'h101120213031);

    // Backpressure for 10 cycles, then full-rate drain.
    b0.m_tready = 1'b0;
    q0[1].push_back(9'h050); q0[1].push_back(9'h051); q0[1].push_back(9'h052);
    q0[1].push_back(9'h053); q0[1].push_back(9'h154);
    step(2);
    for (int k = 0; k < 10; k++) begin
      check("t4_hold_vld", b0.m_tvalid, 1);
      check("t4_hold_dat", b0.m_tdata, 8'h50);
      check("t4_hold_rdy", b0.req_tready[1], 0);
      step(1);
    end
    b0.m_tready = 1'b1;
    step(8);
    for (int k = 1; k < 5; k++)
      if (k < outc0.size()) check("t4_gap", outc0[k] - outc0[k-1], 1);
    check_stream("t4", 0, 5, 64'h5051525354);

    // Timeout: req1 abandons its packet, req2 waits.
    q0[1].push_back(9'h041);
    step(1);
    check("t5_grant1", b0.grant_id, 1);
    q0[2].push_back(9'h142);
    step(1);
    check("t5_acc_dat", b0.m_tdata, 8'h41);
    check("t5_acc_vld", b0.m_tvalid, 1);
    step(7);
    check("t5_held_busy", b0.busy, 1);
    check("t5_held_grant", b0.grant_id, 1);
    step(1);
    check("t5_released", b0.busy, 0);
    step(1);
    check("t5_grant2", b0.grant_id, 2);
    check("t5_busy2", b0.busy, 1);
    step(4);
    check_stream("t5", 0, 2, 64'h4142);

    // Per-beat re-arbitration alternates the two streams.
    q1[0].push_back(9'h0A0); q1[0].push_back(9'h0A1); q1[0].push_back(9'h1A2);
    q1[1].push_back(9'h0B0); q1[1].push_back(9'h0B1); q1[1].push_back(9'h1B2);
    step(20);
    check_stream("t6", 1, 6, 64'hA0B0A1B1A2B2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
